cfg_bus_arbiter: RTL and testbench

CFG_BUS_ARBITER -- requirements
Module: cfg_bus_arbiter

---
 rtl/cfg_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_bus_arbiter
//  Purpose  : Two-requester round-robin arbiter driving a shared configuration
//             bus. Issues one transfer at a time, waits for every slave to be
//             ready, aborts on timeout and inserts a one-cycle gap between
//             transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_bus_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 14,
    parameter int N_SLV   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,

    output logic              c_valid,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data,
    input  logic [N_SLV-1:0]  c_ready,

    output logic              done,
    output logic              timeout_err,
    output logic              err_src,
    output logic [7:0]        timeout_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Last ISSUE cycle index before an abort is declared.
    localparam logic [7:0] c_last_cycle = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_last_grant;   // id of the most recently granted requester
    logic       r_id;           // id of the transfer in flight
    logic [7:0] r_cnt;          // ISSUE cycles elapsed for the current transfer

    logic       w_any_req;
    logic       w_grant_id;
    logic       w_accept;
    logic       w_all_ready;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign w_any_req   = req0_valid | req1_valid;
    assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_all_ready = &c_ready;

    // State register; reset returns to IDLE at once, dropping c_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and the combinational handshake / pulse outputs.
    always_comb begin
        w_next      = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        c_valid     = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        busy        = 1'b1;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                // Ready is gated by rst so nothing is accepted while held in reset.
                if (rst && w_any_req) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                    if (w_grant_id) begin
                        req1_ready = 1'b1;
                    end else begin
                        req0_ready = 1'b1;
                    end
                end
            end
            ISSUE: begin
                c_valid = 1'b1;
                // Completion takes priority over a timeout in the same cycle.
                if (w_all_ready) begin
                    done   = 1'b1;
                    w_next = GAP;
                end else if (r_cnt == c_last_cycle) begin
                    timeout_err = 1'b1;
                    w_next      = GAP;
                end
            end
            GAP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Transaction capture, ISSUE cycle counter and abort bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_addr       <= '0;
            c_data       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 8'd0;
            err_src      <= 1'b0;
            timeout_cnt  <= 8'd0;
        end else begin
            if (w_accept) begin
                c_addr       <= w_grant_id ? req1_addr : req0_addr;
                c_data       <= w_grant_id ? req1_data : req0_data;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_cnt        <= 8'd0;
            end else if (r_state == ISSUE) begin
                if (done) begin
                    r_cnt <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            if (timeout_err) begin
                err_src <= r_id;
                if (timeout_cnt != 8'hFF) begin
                    timeout_cnt <= timeout_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_bus_arbiter
//  Purpose  : Directed self-checking bench for cfg_bus_arbiter. A default
//             instance and a TIMEOUT=8 instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [13:0] req0_data, req1_data;
    logic [2:0]  c_ready;

    logic        d_req0_ready, d_req1_ready, d_c_valid, d_done, d_timeout_err, d_err_src, d_busy;
    logic [3:0]  d_c_addr;
    logic [13:0] d_c_data;
    logic [7:0]  d_timeout_cnt;

    logic        t_req0_ready, t_req1_ready, t_c_valid, t_done, t_timeout_err, t_err_src, t_busy;
    logic [3:0]  t_c_addr;
    logic [13:0] t_c_data;
    logic [7:0]  t_timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cfg_bus_arbiter u_dut_def (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(d_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(d_req1_ready),
        .c_valid(d_c_valid), .c_addr(d_c_addr), .c_data(d_c_data), .c_ready(c_ready),
        .done(d_done), .timeout_err(d_timeout_err), .err_src(d_err_src),
        .timeout_cnt(d_timeout_cnt), .busy(d_busy)
    );

    cfg_bus_arbiter #(.TIMEOUT(8)) u_dut_t8 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(t_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(t_req1_ready),
        .c_valid(t_c_valid), .c_addr(t_c_addr), .c_data(t_c_data), .c_ready(c_ready),
        .done(t_done), .timeout_err(t_timeout_err), .err_src(t_err_src),
        .timeout_cnt(t_timeout_cnt), .busy(t_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 1'b0; req0_addr = 4'h0; req0_data = 14'h0;
        req1_valid = 1'b0; req1_addr = 4'h0; req1_data = 14'h0;
        c_ready    = 3'b000;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        tick();

        // Reset state, readies forced low even with both requesters valid
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_req0_ready", 32'(d_req0_ready), 32'd0);
        check("rst_req1_ready", 32'(d_req1_ready), 32'd0);
        check("rst_c_valid",    32'(d_c_valid),    32'd0);
        check("rst_c_addr",     32'(d_c_addr),     32'd0);
        check("rst_c_data",     32'(d_c_data),     32'd0);
        check("rst_busy",       32'(d_busy),       32'd0);
        check("rst_err_src",    32'(d_err_src),    32'd0);
        check("rst_tcnt",       32'(d_timeout_cnt),32'd0);
        check("rst_done",       32'(d_done),       32'd0);

        // Single transfer
        req1_valid = 1'b0;
        req0_addr  = 4'h3;
        req0_data  = 14'h0155;
        c_ready    = 3'b111;
        rst        = 1'b1;
        #1;
        check("single_req0_ready", 32'(d_req0_ready), 32'd1);
        check("single_req1_ready", 32'(d_req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req0_addr  = 4'hF;
        req0_data  = 14'h3FFF;
        #1;
        check("single_c_valid", 32'(d_c_valid), 32'd1);
        check("single_c_addr",  32'(d_c_addr),  32'h3);
        check("single_c_data",  32'(d_c_data),  32'h0155);
        check("single_done",    32'(d_done),    32'd1);
        check("single_busy",    32'(d_busy),    32'd1);
        tick();
        check("gap_c_valid",    32'(d_c_valid), 32'd0);
        check("gap_done",       32'(d_done),    32'd0);
        check("gap_c_addr",     32'(d_c_addr),  32'h3);
        check("gap_busy",       32'(d_busy),    32'd1);
        tick();
        check("idle_busy",      32'(d_busy),    32'd0);

        // Tie arbitration: req0, req1, req0 three cycles apart
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'h1; req0_data = 14'h0011;
        req1_valid = 1'b1; req1_addr = 4'h2; req1_data = 14'h0022;
        c_ready    = 3'b111;
        for (int k = 0; k < 7; k++) begin
            #1;
            check($sformatf("tie_req0_c%0d", k), 32'(d_req0_ready), 32'((k == 0) || (k == 6)));
            check($sformatf("tie_req1_c%0d", k), 32'(d_req1_ready), 32'(k == 3));
            if (k == 4) check("tie_c_addr_req1", 32'(d_c_addr), 32'h2);
            tick();
        end

        // Partial ready: ten cycles of 3'b011, completion on the eleventh
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'h5; req0_data = 14'h1ABC;
        c_ready    = 3'b011;
        #1;
        check("part_req0_ready", 32'(d_req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req0_addr  = 4'h0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) c_ready = 3'b111;
            #1;
            check($sformatf("part_c_valid_c%0d", k), 32'(d_c_valid),     32'd1);
            check($sformatf("part_c_addr_c%0d", k),  32'(d_c_addr),      32'h5);
            check($sformatf("part_c_data_c%0d", k),  32'(d_c_data),      32'h1ABC);
            check($sformatf("part_done_c%0d", k),    32'(d_done),        32'(k == 11));
            check($sformatf("part_terr_c%0d", k),    32'(d_timeout_err), 32'd0);
            tick();
        end
        check("part_gap_c_valid", 32'(d_c_valid), 32'd0);

        // Timeout with TIMEOUT=8, requester 1
        do_reset();
        req1_valid = 1'b1; req1_addr = 4'hA; req1_data = 14'h2222;
        c_ready    = 3'b000;
        #1;
        check("to_req1_ready", 32'(t_req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check($sformatf("to_c_valid_c%0d", k), 32'(t_c_valid),     32'd1);
            check($sformatf("to_terr_c%0d", k),    32'(t_timeout_err), 32'(k == 8));
            tick();
        end
        check("to_err_src",  32'(t_err_src),     32'd1);
        check("to_tcnt",     32'(t_timeout_cnt), 32'd1);
        check("to_c_valid",  32'(t_c_valid),     32'd0);
        tick();

        // Boundary: all ready exactly in the 8th ISSUE cycle counts as completion
        req0_valid = 1'b1; req0_addr = 4'h6; req0_data = 14'h0666;
        #1;
        check("bnd_req0_ready", 32'(t_req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) c_ready = 3'b111;
            #1;
            check($sformatf("bnd_done_c%0d", k), 32'(t_done),        32'(k == 8));
            check($sformatf("bnd_terr_c%0d", k), 32'(t_timeout_err), 32'd0);
            tick();
        end
        check("bnd_tcnt",    32'(t_timeout_cnt), 32'd1);
        check("bnd_err_src", 32'(t_err_src),     32'd1);
        c_ready = 3'b000;
        tick();

        // 299 further aborts saturate the counter at 255
        for (int i = 0; i < 299; i++) begin
            req1_valid = 1'b1;
            tick();
            req1_valid = 1'b0;
            repeat (9) tick();
        end
        #1;
        check("sat_tcnt", 32'(t_timeout_cnt), 32'd255);
        check("sat_busy", 32'(t_busy),        32'd0);

        // Reset in the 3rd ISSUE cycle
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'h9; req0_data = 14'h0777;
        c_ready    = 3'b000;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        #1;
        check("rmid_c_valid_pre", 32'(d_c_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("rmid_c_valid", 32'(d_c_valid),     32'd0);
        check("rmid_busy",    32'(d_busy),        32'd0);
        check("rmid_c_addr",  32'(d_c_addr),      32'd0);
        check("rmid_c_data",  32'(d_c_data),      32'd0);
        check("rmid_done",    32'(d_done),        32'd0);
        check("rmid_terr",    32'(d_timeout_err), 32'd0);
        check("rmid_tcnt",    32'(d_timeout_cnt), 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("rmid_tie_req0", 32'(d_req0_ready), 32'd1);
        check("rmid_tie_req1", 32'(d_req1_ready), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
